fb_bank_sched: RTL and testbench

Ping-pong frame-buffer scheduler between the camera capture writer and the VGA scan-out reader.
- Owns two 320x240x12-bit banks in one BRAM.
- Generates write addresses and write strobes for the capture stream into the back bank.
- Maps the VGA controller's 0..76799 pixel address onto the front bank.
- Swaps banks only at a VGA frame boundary, so no frame tears.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_wr_addrgen.sv | 33 +++
 rtl/fb_bank_sched.sv | 151 +++++++++++++++
 tb/tb_fb_bank_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared geometry, widths and writer state encoding for the ping-pong frame buffer.
package fb_pkg;
   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FRAME_PIX = FB_W * FB_H;
   localparam int PIX_W     = 12;
   localparam int OFF_W     = 17;
   localparam int ADDR_W    = 18;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_WRITE = 2'd1,
      W_DONE  = 2'd2
   } wr_state_e;
endpackage

// File: rtl/fb_wr_addrgen.sv
// In-frame write offset counter: a write either uses the current offset or is forced to
// offset zero, and the counter then moves to the following pixel, wrapping after the last one.
module fb_wr_addrgen #(
   parameter int FRAME_PIX = fb_pkg::FRAME_PIX,
   parameter int OFF_W     = fb_pkg::OFF_W
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             wr_i,
   input  logic             ld_zero_i,
   output logic [OFF_W-1:0] off_o,
   output logic             last_o
);
   logic [OFF_W-1:0] off_q, off_d;

   assign off_o  = ld_zero_i ? '0 : off_q;
   assign last_o = (off_o == OFF_W'(FRAME_PIX - 1));

   always_comb begin
      off_d = off_q;
      if (wr_i) begin
         off_d = last_o ? '0 : off_o + OFF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         off_q <= '0;
      end else begin
         off_q <= off_d;
      end
   end
endmodule

// File: rtl/fb_bank_sched.sv
// Ping-pong frame-buffer scheduler: capture writes fill the back bank, VGA reads the
// front bank, and the two are exchanged only on a VGA frame start once a frame is complete.
module fb_bank_sched #(
   parameter int FRAME_PIX = fb_pkg::FRAME_PIX,
   parameter int PIX_W     = fb_pkg::PIX_W,
   parameter int OFF_W     = fb_pkg::OFF_W,
   parameter int ADDR_W    = fb_pkg::ADDR_W,
   parameter int CNT_W     = fb_pkg::CNT_W
) (
   input  logic              clk25,
   input  logic              rst_clk25,
   input  logic              wr_valid,
   input  logic              wr_sof,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              rd_frame_start,
   input  logic [OFF_W-1:0]  rd_pix_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_dout,
   output logic              disp_bank,
   output logic              swap_pulse,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  err_cnt
);
   import fb_pkg::*;

   typedef logic [ADDR_W-1:0] addr_t;

   function automatic addr_t bank_base(input logic bank);
      return bank ? addr_t'(FRAME_PIX) : '0;
   endfunction

   wr_state_e        state_q, state_d;
   logic             disp_q, disp_d, wrb_q, wrb_d;
   logic             wr_en_q, swap_q, swap_d;
   addr_t            wr_addr_q;
   logic [PIX_W-1:0] wr_dout_q;
   logic [CNT_W-1:0] drop_q, err_q;
   logic             do_wr, ld_zero, sel_bank, drop_inc, err_inc, last;
   logic             sof;
   logic [OFF_W-1:0] off;

   assign sof = wr_valid & wr_sof;

   fb_wr_addrgen #(
      .FRAME_PIX (FRAME_PIX),
      .OFF_W     (OFF_W)
   ) u_addrgen (
      .clk       (clk25),
      .srst      (rst_clk25),
      .wr_i      (do_wr),
      .ld_zero_i (ld_zero),
      .off_o     (off),
      .last_o    (last)
   );

   always_comb begin
      state_d  = state_q;
      disp_d   = disp_q;
      wrb_d    = wrb_q;
      swap_d   = 1'b0;
      do_wr    = 1'b0;
      ld_zero  = 1'b0;
      sel_bank = wrb_q;
      drop_inc = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         W_IDLE: begin
            if (sof) begin
               do_wr   = 1'b1;
               ld_zero = 1'b1;
               state_d = W_WRITE;
            end
         end
         W_WRITE: begin
            if (sof) begin
               err_inc = 1'b1;
               do_wr   = 1'b1;
               ld_zero = 1'b1;
            end else if (wr_valid) begin
               do_wr = 1'b1;
               if (last) begin
                  state_d = W_DONE;
               end
            end
         end
         W_DONE: begin
            if (rd_frame_start) begin
               disp_d = wrb_q;
               wrb_d  = disp_q;
               swap_d = 1'b1;
               // A coincident sof goes straight into the bank that just left the display.
               if (sof) begin
                  do_wr    = 1'b1;
                  ld_zero  = 1'b1;
                  sel_bank = disp_q;
                  state_d  = W_WRITE;
               end else begin
                  state_d = W_IDLE;
               end
            end else if (sof) begin
               drop_inc = 1'b1;
               do_wr    = 1'b1;
               ld_zero  = 1'b1;
               state_d  = W_WRITE;
            end
         end
         default: state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (rst_clk25) begin
         state_q   <= W_IDLE;
         disp_q    <= 1'b0;
         wrb_q     <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dout_q <= '0;
         swap_q    <= 1'b0;
         drop_q    <= '0;
         err_q     <= '0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         wrb_q   <= wrb_d;
         wr_en_q <= do_wr;
         swap_q  <= swap_d;
         if (do_wr) begin
            wr_addr_q <= bank_base(sel_bank) + addr_t'(off);
            wr_dout_q <= wr_data;
         end
         if (drop_inc && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
         end
         if (err_inc && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
         end
      end
   end

   assign rd_addr    = bank_base(disp_q) + addr_t'(rd_pix_addr);
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_dout    = wr_dout_q;
   assign disp_bank  = disp_q;
   assign swap_pulse = swap_q;
   assign drop_cnt   = drop_q;
   assign err_cnt    = err_q;
endmodule

// File: tb/tb_fb_bank_sched.sv
// Directed bench for fb_bank_sched with a 16-pixel frame: a table of per-cycle vectors
// followed by hand-written drop-saturation and mid-frame reset sequences.
module tb_fb_bank_sched;
   localparam int FP = 16;

   logic        clk25 = 1'b0;
   logic        rst_clk25, wr_valid, wr_sof, rd_frame_start;
   logic [11:0] wr_data;
   logic [16:0] rd_pix_addr;
   logic [17:0] rd_addr, wr_addr;
   logic        wr_en, disp_bank, swap_pulse;
   logic [11:0] wr_dout;
   logic [7:0]  drop_cnt, err_cnt;

   initial forever #5 clk25 = ~clk25;

   fb_bank_sched #(.FRAME_PIX(FP)) dut (
      .clk25          (clk25),
      .rst_clk25      (rst_clk25),
      .wr_valid       (wr_valid),
      .wr_sof         (wr_sof),
      .wr_data        (wr_data),
      .rd_frame_start (rd_frame_start),
      .rd_pix_addr    (rd_pix_addr),
      .rd_addr        (rd_addr),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_dout        (wr_dout),
      .disp_bank      (disp_bank),
      .swap_pulse     (swap_pulse),
      .drop_cnt       (drop_cnt),
      .err_cnt        (err_cnt)
   );

   typedef struct {
      bit          rst, v, sof, fs;
      logic [11:0] d;
      logic [16:0] pa;
      bit          e_en;
      logic [17:0] e_addr;
      bit          e_swap, e_disp;
      logic [17:0] e_rd;
      logic [7:0]  e_drop, e_err;
   } vec_t;

   vec_t        vecs[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   bit          b_disp;
   logic [7:0]  b_drop, b_err;
   logic [16:0] b_pa;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // addr < 0 means no write is expected on the cycle after this row.
   task automatic add(input bit rst, input bit v, input bit sof, input bit fs,
                      input int addr, input bit swap);
      vec_t t;
      t.rst    = rst;
      t.v      = v;
      t.sof    = sof;
      t.fs     = fs;
      t.d      = 12'($urandom);
      t.pa     = b_pa;
      t.e_en   = (addr >= 0);
      t.e_addr = (addr >= 0) ? 18'(addr) : 18'd0;
      t.e_swap = swap;
      t.e_disp = b_disp;
      t.e_rd   = (b_disp ? 18'(FP) : 18'd0) + 18'(b_pa);
      t.e_drop = b_drop;
      t.e_err  = b_err;
      vecs.push_back(t);
   endtask

   task automatic chk(input string what, input string ctx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (%s): actual=%0d required=%0d", what, ctx, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit v, input bit sof, input bit fs,
                        input logic [11:0] d, input logic [16:0] pa);
      rst_clk25      = rst;
      wr_valid       = v;
      wr_sof         = sof;
      rd_frame_start = fs;
      wr_data        = d;
      rd_pix_addr    = pa;
   endtask

   task automatic check_out(input string ctx, input bit en, input logic [17:0] addr,
                            input logic [11:0] dout, input bit swap, input bit disp,
                            input logic [17:0] rd, input logic [7:0] drop,
                            input logic [7:0] err);
      chk("wr_en", ctx, 32'(wr_en), 32'(en));
      if (en) begin
         chk("wr_addr", ctx, 32'(wr_addr), 32'(addr));
         chk("wr_dout", ctx, 32'(wr_dout), 32'(dout));
      end
      chk("swap_pulse", ctx, 32'(swap_pulse), 32'(swap));
      chk("disp_bank", ctx, 32'(disp_bank), 32'(disp));
      chk("rd_addr", ctx, 32'(rd_addr), 32'(rd));
      chk("drop_cnt", ctx, 32'(drop_cnt), 32'(drop));
      chk("err_cnt", ctx, 32'(err_cnt), 32'(err));
   endtask

   task automatic step(input bit rst, input bit v, input bit sof, input bit fs,
                       input logic [11:0] d, input logic [16:0] pa);
      drive(rst, v, sof, fs, d, pa);
      @(posedge clk25);
      #1;
   endtask

   initial begin
      logic [11:0] d;
      logic [7:0]  exp_drop;

      // Reset with random inputs.
      b_disp = 1'b0; b_drop = 8'd0; b_err = 8'd0; b_pa = 17'd5;
      add(1'b1, rb(), rb(), rb(), -1, 1'b0);
      add(1'b1, rb(), rb(), rb(), -1, 1'b0);

      // Full frame into bank 1, then swap.
      b_pa = 17'd0;
      add(0, 1, 1, 0, FP, 0);
      for (int i = 1; i < FP; i++) add(0, 1, 0, 0, FP + i, 0);
      add(0, 0, 0, 0, -1, 0);
      add(0, 1, 0, 0, -1, 0);
      b_pa = 17'd3; b_disp = 1'b1;
      add(0, 0, 0, 1, -1, 1);
      add(0, 0, 0, 0, -1, 0);

      // Frame start in idle and on the last pixel do not swap; the next one does.
      add(0, 1, 0, 0, -1, 0);
      add(0, 0, 0, 1, -1, 0);
      add(0, 1, 1, 0, 0, 0);
      for (int i = 1; i < FP - 1; i++) add(0, 1, 0, 0, i, 0);
      add(0, 1, 0, 1, FP - 1, 0);
      add(0, 0, 0, 0, -1, 0);
      add(0, 1, 0, 0, -1, 0);
      b_disp = 1'b0;
      add(0, 0, 0, 1, -1, 1);
      add(0, 0, 0, 0, -1, 0);

      // Short frame: sof after 7 pixels restarts at offset 0 of bank 1.
      add(0, 1, 1, 0, FP, 0);
      for (int i = 1; i < 7; i++) add(0, 1, 0, 0, FP + i, 0);
      b_err = 8'd1;
      add(0, 1, 1, 0, FP, 0);
      for (int i = 1; i < FP; i++) add(0, 1, 0, 0, FP + i, 0);
      add(0, 1, 0, 0, -1, 0);

      // Drop: completed frame overwritten in the same back bank.
      b_drop = 8'd1;
      add(0, 1, 1, 0, FP, 0);
      for (int i = 1; i < FP; i++) add(0, 1, 0, 0, FP + i, 0);

      // Swap and sof together: swap wins, sof lands at base of old display bank 0.
      b_disp = 1'b1;
      add(0, 1, 1, 1, 0, 1);
      for (int i = 1; i < FP; i++) add(0, 1, 0, 0, i, 0);
      add(0, 0, 0, 0, -1, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].fs, vecs[i].d, vecs[i].pa);
         @(posedge clk25);
         #1;
         check_out($sformatf("row %0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].d,
                   vecs[i].e_swap, vecs[i].e_disp, vecs[i].e_rd, vecs[i].e_drop,
                   vecs[i].e_err);
         if (vecs[i].rst) begin
            chk("wr_addr_rst", $sformatf("row %0d", i), 32'(wr_addr), 32'd0);
            chk("wr_dout_rst", $sformatf("row %0d", i), 32'(wr_dout), 32'd0);
         end
         $display("row %0d rst=%0b v=%0b sof=%0b fs=%0b -> wr_en=%0b wr_addr=%0d swap=%0b disp=%0b drop=%0d err=%0d",
                  i, vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].fs, wr_en, wr_addr,
                  swap_pulse, disp_bank, drop_cnt, err_cnt);
      end

      // 300 drops into bank 0 (display is bank 1); counter saturates at 255.
      for (int k = 0; k < 300; k++) begin
         d = 12'($urandom);
         step(0, 1, 1, 0, d, 17'd3);
         exp_drop = (k + 2 > 255) ? 8'd255 : 8'(k + 2);
         check_out($sformatf("drop %0d", k), 1'b1, 18'd0, d, 1'b0, 1'b1, 18'd19,
                   exp_drop, 8'd1);
         for (int j = 1; j < FP; j++) begin
            d = 12'($urandom);
            step(0, 1, 0, 0, d, 17'd3);
            if (j == FP - 1) chk("last_addr", $sformatf("drop %0d", k), 32'(wr_addr), 32'(FP - 1));
         end
         $display("drop %0d -> drop_cnt=%0d", k, drop_cnt);
      end
      step(0, 0, 0, 0, 12'd0, 17'd3);
      chk("drop_sat", "after drops", 32'(drop_cnt), 32'd255);
      $display("drops done -> drop_cnt=%0d err_cnt=%0d", drop_cnt, err_cnt);

      // Reset in the middle of a frame abandons it and restores reset values.
      step(0, 1, 1, 0, 12'h111, 17'd3);
      for (int j = 1; j < 4; j++) step(0, 1, 0, 0, 12'(j), 17'd3);
      step(1, 1, 1, 1, 12'hABC, 17'd3);
      check_out("midframe rst", 1'b0, 18'd0, 12'd0, 1'b0, 1'b0, 18'd3, 8'd0, 8'd0);
      chk("wr_addr_rst", "midframe rst", 32'(wr_addr), 32'd0);
      chk("wr_dout_rst", "midframe rst", 32'(wr_dout), 32'd0);
      $display("midframe reset -> wr_en=%0b disp=%0b drop=%0d err=%0d",
               wr_en, disp_bank, drop_cnt, err_cnt);
      step(0, 1, 1, 0, 12'h5A5, 17'd3);
      check_out("post rst sof", 1'b1, 18'(FP), 12'h5A5, 1'b0, 1'b0, 18'd3, 8'd0, 8'd0);
      step(0, 1, 0, 0, 12'h0F0, 17'd3);
      check_out("post rst pix", 1'b1, 18'(FP + 1), 12'h0F0, 1'b0, 1'b0, 18'd3, 8'd0, 8'd0);
      $display("post reset frame -> wr_addr=%0d", wr_addr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
